line_batch_sequencer: RTL

//  Synthesizable batch driver for the line-processing Controller/Datapath core. It replaces fixed-delay

---
 rtl/line_seq_pkg.sv | 12 +
 rtl/seq_watchdog.sv | 18 +
 rtl/line_batch_sequencer.sv | 90 +++++++++
 3 files changed

// File: rtl/line_seq_pkg.sv
// line_seq_pkg: shared widths, state encoding and markers for the line batch sequencer.
package line_seq_pkg;
   localparam int LINE_W_DEF  = 25;
   localparam int DEPTH_DEF   = 64;
   localparam int ADDR_W_DEF  = 6;
   localparam int TIMEOUT_DEF = 255;
   localparam int WD_W        = 16;
   localparam logic [LINE_W_DEF-1:0] LINE_EOF = '1;
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_LAUNCH, S_RUN, S_STORE, S_FINISH
   } state_t;
endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: per-line cycle counter; expired flags the last allowed RUN cycle.
module seq_watchdog import line_seq_pkg::*; #(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   logic [WD_W-1:0] cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   // cnt holds completed RUN cycles, so this fires on RUN cycle number TIMEOUT
   assign expired = en && (cnt == WD_W'(TIMEOUT - 1));
endmodule

// File: rtl/line_batch_sequencer.sv
// line_batch_sequencer: feeds source RAM lines through the core with a start/done
// handshake and per-line watchdog, writing results (or an all-ones marker) in order.
module line_batch_sequencer import line_seq_pkg::*; #(
   parameter int LINE_W  = LINE_W_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic [ADDR_W:0]   num_lines,
   output logic [ADDR_W-1:0] in_addr,
   input  logic [LINE_W-1:0] in_data,
   output logic              core_start,
   output logic [LINE_W-1:0] core_line,
   output logic [ADDR_W-1:0] core_count,
   input  logic              core_done,
   input  logic [LINE_W-1:0] core_result,
   output logic              out_we,
   output logic [ADDR_W-1:0] out_addr,
   output logic [LINE_W-1:0] out_data,
   output logic              busy,
   output logic              batch_done,
   output logic              timeout_err,
   output logic [ADDR_W:0]   err_count
);
   state_t state, state_d;
   logic [ADDR_W:0] n_q, idx, n_lim;
   logic [LINE_W-1:0] res_q;
   logic expired, accept;
   assign n_lim  = (num_lines > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_lines;
   assign accept = (state == S_IDLE) && go;
   seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk(clk), .rst(rst), .clr(state == S_LAUNCH), .en(state == S_RUN), .expired(expired)
   );
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:   if (go) state_d = (n_lim == '0) ? S_FINISH : S_FETCH;
         S_FETCH:  state_d = S_WAIT;
         S_WAIT:   state_d = S_LAUNCH;
         S_LAUNCH: state_d = S_RUN;
         S_RUN:    if (core_done || expired) state_d = S_STORE;
         S_STORE:  state_d = (idx == n_q - 1'b1) ? S_FINISH : S_FETCH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end
   assign in_addr    = idx[ADDR_W-1:0];
   assign out_addr   = idx[ADDR_W-1:0];
   assign out_data   = res_q;
   assign out_we     = (state == S_STORE);
   assign core_start = (state == S_LAUNCH);
   assign busy       = (state != S_IDLE);
   assign batch_done = (state == S_FINISH);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state       <= S_IDLE;
         n_q         <= '0;
         idx         <= '0;
         core_line   <= '0;
         core_count  <= '0;
         res_q       <= '0;
         timeout_err <= 1'b0;
         err_count   <= '0;
      end else begin
         state <= state_d;
         if (accept) begin
            n_q         <= n_lim;
            idx         <= '0;
            timeout_err <= 1'b0;
            err_count   <= '0;
         end
         if (state == S_WAIT) begin
            core_line  <= in_data;
            core_count <= idx[ADDR_W-1:0];
         end
         // a result arriving on the expiry cycle still counts as healthy
         if (state == S_RUN) begin
            if (core_done) res_q <= core_result;
            else if (expired) begin
               res_q       <= '1;
               timeout_err <= 1'b1;
               err_count   <= err_count + 1'b1;
            end
         end
         if (state == S_STORE) idx <= idx + 1'b1;
      end
endmodule
